// File: rtl/rect_filler_pkg.sv
// ============================================================================
// Module      : rect_filler_pkg
// Description : Shared state encoding, burst geometry and address-field
//               widths for the rectangle filler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rect_filler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA2 = 2'd2
    } state_t;

    localparam int PIX_PER_BURST = 8;
    localparam int PIX_PER_BEAT  = 4;
    localparam int BYTES_PER_PIX = 4;

    localparam int BEAT_W = PIX_PER_BEAT * BYTES_PER_PIX * 8;
    localparam int MASK_W = PIX_PER_BEAT * BYTES_PER_PIX;

    // Burst address = {pad, frame select, row, burst column, beat-byte lsbs}
    localparam int ADDR_PAD_W   = 6;
    localparam int ADDR_FRAME_W = 6;
    localparam int ADDR_ROW_W   = 10;
    localparam int ADDR_COL_W   = 7;
    localparam int ADDR_LSB_W   = 2;
    localparam int ADDR_W       = ADDR_PAD_W + ADDR_FRAME_W + ADDR_ROW_W
                                + ADDR_COL_W + ADDR_LSB_W;

endpackage

`default_nettype wire

// File: rtl/rect_filler_mask.sv
// ============================================================================
// Module      : rect_filler_mask
// Description : Combinational per-byte edge mask for one write beat
//               (1 = byte not written).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_filler_mask
    import rect_filler_pkg::*;
#(
    parameter int X_W = 10
) (
    input  logic [X_W-1:0]    xb,
    input  logic              beat,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    output logic [MASK_W-1:0] mask
);

    for (genvar p = 0; p < PIX_PER_BEAT; p++) begin : g_pix
        logic [X_W-1:0] w_pix;

        assign w_pix = xb + X_W'(beat ? PIX_PER_BEAT + p : p);
        assign mask[BYTES_PER_PIX*p +: BYTES_PER_PIX] =
            ((w_pix < x0) || (w_pix > x1)) ? {BYTES_PER_PIX{1'b1}}
                                           : {BYTES_PER_PIX{1'b0}};
    end

endmodule

`default_nettype wire

// File: rtl/rect_filler.sv
// ============================================================================
// Module      : rect_filler
// Description : Fills a framebuffer rectangle with a colour using two-beat
//               DDR2 write bursts. Optional macro RECT_FILLER_CLIP_EN clamps
//               the rectangle to the frame and drops empty commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_filler
    import rect_filler_pkg::*;
#(
    parameter int FRAME_W = 800,
    parameter int FRAME_H = 600,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    input  logic [23:0]       color,
    input  logic [31:0]       frame_base,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [BEAT_W-1:0] wdf_din,
    output logic              wdf_wr_en,
    output logic [MASK_W-1:0] wdf_mask_din,
    output logic              done
);

    state_t                  r_state;
    state_t                  w_next;
    logic [X_W-1:0]          r_x0;
    logic [X_W-1:0]          r_x1;
    logic [X_W-1:0]          r_xb;
    logic [Y_W-1:0]          r_y1;
    logic [Y_W-1:0]          r_yr;
    logic [23:0]             r_color;
    logic [ADDR_FRAME_W-1:0] r_frame;

    logic [X_W-1:0]          w_x1_in;
    logic [Y_W-1:0]          w_y1_in;
    logic [X_W-1:0]          w_xb_next;
    logic                    w_x_more;
    logic                    w_y_more;
    logic                    w_empty;
    logic                    w_beat;
    logic                    w_unused;

    assign w_unused = ^{frame_base[31:28], frame_base[21:0]};

`ifdef RECT_FILLER_CLIP_EN
    localparam logic [X_W-1:0] C_X_MAX = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] C_Y_MAX = Y_W'(FRAME_H - 1);

    logic r_empty;
    logic w_empty_in;

    assign w_x1_in    = (x1 > C_X_MAX) ? C_X_MAX : x1;
    assign w_y1_in    = (y1 > C_Y_MAX) ? C_Y_MAX : y1;
    assign w_empty_in = (x0 > w_x1_in) || (y0 > w_y1_in)
                     || (x0 > C_X_MAX) || (y0 > C_Y_MAX);
    assign w_empty    = r_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_empty <= 1'b0;
        end else if (r_state == IDLE && valid) begin
            r_empty <= w_empty_in;
        end
    end
`else
    assign w_x1_in = x1;
    assign w_y1_in = y1;
    assign w_empty = 1'b0;
`endif

    assign w_xb_next = r_xb + X_W'(PIX_PER_BURST);
    assign w_x_more  = (w_xb_next <= r_x1);
    assign w_y_more  = (r_yr < r_y1);
    assign w_beat    = (r_state == DATA2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ready     = 1'b0;
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (valid) w_next = CMD;
            end
            CMD: begin
                if (w_empty) begin
                    done   = 1'b1;
                    w_next = IDLE;
                end else if (!af_full && !wdf_full) begin
                    af_wr_en  = 1'b1;
                    wdf_wr_en = 1'b1;
                    w_next    = DATA2;
                end
            end
            DATA2: begin
                if (!wdf_full) begin
                    wdf_wr_en = 1'b1;
                    if (w_x_more || w_y_more) begin
                        w_next = CMD;
                    end else begin
                        done   = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Burst x is aligned down to a PIX_PER_BURST (8-pixel) boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x0    <= '0;
            r_x1    <= '0;
            r_xb    <= '0;
            r_y1    <= '0;
            r_yr    <= '0;
            r_color <= '0;
            r_frame <= '0;
        end else if (r_state == IDLE && valid) begin
            r_x0    <= x0;
            r_x1    <= w_x1_in;
            r_xb    <= {x0[X_W-1:3], 3'b000};
            r_y1    <= w_y1_in;
            r_yr    <= y0;
            r_color <= color;
            r_frame <= frame_base[27:22];
        end else if (r_state == DATA2 && !wdf_full) begin
            if (w_x_more) begin
                r_xb <= w_xb_next;
            end else if (w_y_more) begin
                r_yr <= r_yr + 1'b1;
                r_xb <= {r_x0[X_W-1:3], 3'b000};
            end
        end
    end

    assign af_addr_din = {{ADDR_PAD_W{1'b0}}, r_frame, ADDR_ROW_W'(r_yr),
                          ADDR_COL_W'(r_xb >> 3), {ADDR_LSB_W{1'b0}}};
    assign wdf_din     = {PIX_PER_BEAT{8'h00, r_color}};

    rect_filler_mask #(
        .X_W (X_W)
    ) u_mask (
        .xb   (r_xb),
        .beat (w_beat),
        .x0   (r_x0),
        .x1   (r_x1),
        .mask (wdf_mask_din)
    );

endmodule

`default_nettype wire

// File: tb/tb_rect_filler.sv
// ============================================================================
// Module      : tb_rect_filler
// Description : Self-checking bench for rect_filler (directed vectors plus
//               backpressure, reset and clipping sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rect_filler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic         ready;
    logic [9:0]   x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [23:0]  color = '0;
    logic [31:0]  frame_base = '0;
    logic         af_full = 1'b0, wdf_full = 1'b0;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic         wdf_wr_en;
    logic [15:0]  wdf_mask_din;
    logic         done;

    always #5 clk = ~clk;

    rect_filler #(.FRAME_W(800), .FRAME_H(600), .X_W(10), .Y_W(10)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .frame_base(frame_base), .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
        .wdf_wr_en(wdf_wr_en), .wdf_mask_din(wdf_mask_din), .done(done)
    );

    int           n_chk = 0;
    int           n_pass = 0;
    logic [30:0]  q_addr[$];
    logic [15:0]  q_mask[$];
    int           bad_data = 0;
    int           done_cnt = 0;
    logic [127:0] exp_data = '0;

    // Pushes are committed at the next rising edge; inputs only change just after it.
    always @(negedge clk) begin
        if (rst) begin
            if (af_wr_en) q_addr.push_back(af_addr_din);
            if (wdf_wr_en) begin
                q_mask.push_back(wdf_mask_din);
                if (wdf_din !== exp_data) bad_data++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] addr_at(input int idx);
        if (idx >= 0 && idx < q_addr.size()) return {1'b0, q_addr[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] mask_at(input int idx);
        if (idx >= 0 && idx < q_mask.size()) return {16'h0, q_mask[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic start_cmd(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                             input logic [9:0] d, input logic [31:0] base, input logic [23:0] col);
        @(posedge clk); #1;
        q_addr.delete(); q_mask.delete();
        bad_data = 0; done_cnt = 0;
        exp_data = {4{8'h00, col}};
        x0 = a; x1 = b; y0 = c; y1 = d; frame_base = base; color = col; valid = 1'b1;
        check("ready_idle", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        // Scramble inputs so any use of un-latched command fields shows up.
        x0 = 10'h155; x1 = 10'h0AA; y0 = 10'h2AA; y1 = 10'h001;
        color = 24'h5A5A5A; frame_base = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit ok);
        cycles = 0; ok = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (done) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [9:0]  x0, x1, y0, y1;
        logic [31:0] base;
        logic [23:0] col;
        int          n_af, n_wdf;
        logic [30:0] a_first, a_last;
        int          cycles;
        logic [15:0] m_first, m_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  ok;
        int  stall;

        vecs[0] = '{10'd3,   10'd12,  10'd5,   10'd5,   32'h1040_0000, 24'hA55AC3,
                    2,    4,    31'h80A00,   31'h80A04,   4,    16'h0FFF, 16'hFFF0};
        vecs[1] = '{10'd0,   10'd799, 10'd0,   10'd9,   32'h0000_0000, 24'h123456,
                    1000, 2000, 31'h00000,   31'h0138C,   2000, 16'h0000, 16'h0000};
        vecs[2] = '{10'd0,   10'd0,   10'd0,   10'd0,   32'hFFC0_0000, 24'hFFFFFF,
                    1,    2,    31'h1F80000, 31'h1F80000, 2,    16'hFFF0, 16'hFFFF};
        vecs[3] = '{10'd795, 10'd799, 10'd599, 10'd599, 32'h0000_0000, 24'h00FF00,
                    1,    2,    31'h4AF8C,   31'h4AF8C,   2,    16'h0FFF, 16'h0000};
        vecs[4] = '{10'd7,   10'd8,   10'd2,   10'd3,   32'h0040_0000, 24'h0F0F0F,
                    4,    8,    31'h80400,   31'h80604,   8,    16'hFFFF, 16'hFFFF};

        // Reset state
        #12;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_af_wr_en", {31'b0, af_wr_en}, 32'd0);
        check("rst_wdf_wr_en", {31'b0, wdf_wr_en}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk); rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            start_cmd(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].base, vecs[i].col);
            @(negedge clk);
            check("ready_busy", {31'b0, ready}, 32'd0);
            wait_done(4000, cyc, ok);
            check("done_seen", {31'b0, ok}, 32'd1);
            check("cycles", cyc + 1, vecs[i].cycles);
            @(negedge clk);
            check("ready_after", {31'b0, ready}, 32'd1);
            repeat (2) @(negedge clk);
            check("af_count", q_addr.size(), vecs[i].n_af);
            check("wdf_count", q_mask.size(), vecs[i].n_wdf);
            check("addr_first", addr_at(0), {1'b0, vecs[i].a_first});
            check("addr_last", addr_at(q_addr.size() - 1), {1'b0, vecs[i].a_last});
            check("mask_first", mask_at(0), {16'h0, vecs[i].m_first});
            check("mask_last", mask_at(q_mask.size() - 1), {16'h0, vecs[i].m_last});
            check("done_pulses", done_cnt, 1);
            check("data_errors", bad_data, 0);
        end

        // Two-burst rectangle: every beat mask and the second address
        start_cmd(10'd3, 10'd12, 10'd5, 10'd5, 32'h1040_0000, 24'h010203);
        wait_done(20, cyc, ok);
        repeat (2) @(negedge clk);
        check("rect_mask0", mask_at(0), 32'h0FFF);
        check("rect_mask1", mask_at(1), 32'h0000);
        check("rect_mask2", mask_at(2), 32'h0000);
        check("rect_mask3", mask_at(3), 32'hFFF0);
        check("rect_addr1", addr_at(1), 32'h80A04);

        // af_full held for 5 cycles in CMD
        af_full = 1'b1;
        start_cmd(10'd3, 10'd12, 10'd5, 10'd5, 32'h1040_0000, 24'h010203);
        stall = 0;
        repeat (5) begin
            @(negedge clk);
            if (af_wr_en || wdf_wr_en || af_addr_din !== 31'h80A00) stall++;
        end
        check("af_full_stall", stall, 0);
        @(posedge clk); #1 af_full = 1'b0;
        #1;
        check("af_resume_af", {31'b0, af_wr_en}, 32'd1);
        check("af_resume_wdf", {31'b0, wdf_wr_en}, 32'd1);
        check("af_resume_addr", {1'b0, af_addr_din}, 32'h80A00);
        wait_done(20, cyc, ok);
        check("af_full_done", {31'b0, ok}, 32'd1);
        repeat (2) @(negedge clk);
        check("af_full_afcnt", q_addr.size(), 2);
        check("af_full_wdfcnt", q_mask.size(), 4);

        // wdf_full held for 3 cycles in DATA2
        start_cmd(10'd3, 10'd12, 10'd5, 10'd5, 32'h1040_0000, 24'h010203);
        @(posedge clk); #1 wdf_full = 1'b1;
        stall = 0;
        repeat (3) begin
            @(negedge clk);
            if (af_wr_en || wdf_wr_en) stall++;
        end
        check("wdf_full_stall", stall, 0);
        @(posedge clk); #1 wdf_full = 1'b0;
        #1;
        check("wdf_resume_wdf", {31'b0, wdf_wr_en}, 32'd1);
        check("wdf_resume_af", {31'b0, af_wr_en}, 32'd0);
        check("wdf_resume_mask", {16'h0, wdf_mask_din}, 32'h0000);
        wait_done(20, cyc, ok);
        repeat (2) @(negedge clk);
        check("wdf_full_afcnt", q_addr.size(), 2);
        check("wdf_full_wdfcnt", q_mask.size(), 4);

        // Asynchronous reset mid-fill, then a fresh command
        start_cmd(10'd0, 10'd799, 10'd0, 10'd9, 32'h0, 24'h777777);
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_af", {31'b0, af_wr_en}, 32'd0);
        check("midrst_wdf", {31'b0, wdf_wr_en}, 32'd0);
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        start_cmd(10'd3, 10'd12, 10'd5, 10'd5, 32'h1040_0000, 24'h010203);
        wait_done(20, cyc, ok);
        repeat (2) @(negedge clk);
        check("postrst_done", {31'b0, ok}, 32'd1);
        check("postrst_afcnt", q_addr.size(), 2);
        check("postrst_addr0", addr_at(0), 32'h80A00);
        check("postrst_mask0", mask_at(0), 32'h0FFF);

`ifdef RECT_FILLER_CLIP_EN
        // Clamped to the frame edge
        start_cmd(10'd0, 10'd1000, 10'd595, 10'd700, 32'h0, 24'h334455);
        wait_done(2000, cyc, ok);
        repeat (2) @(negedge clk);
        check("clip_done", {31'b0, ok}, 32'd1);
        check("clip_afcnt", q_addr.size(), 500);
        check("clip_last_addr", addr_at(q_addr.size() - 1), 32'h4AF8C);
        check("clip_last_mask", mask_at(q_mask.size() - 1), 32'h0000);

        // Entirely outside the frame
        start_cmd(10'd900, 10'd1000, 10'd0, 10'd5, 32'h0, 24'h334455);
        wait_done(10, cyc, ok);
        repeat (2) @(negedge clk);
        check("empty_done", {31'b0, ok}, 32'd1);
        check("empty_cycles", cyc, 1);
        check("empty_afcnt", q_addr.size(), 0);
        check("empty_wdfcnt", q_mask.size(), 0);
        check("empty_pulses", done_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rect_filler.md
Name: rect_filler

Overview:
Parametrised successor to the full-frame filler. Fills an arbitrary axis-aligned rectangle of the framebuffer with a 24-bit colour. Issues proper two-beat DDR2 write bursts (8 pixels per burst) with per-byte edge masking. Sits between the graphics command processor and the DDR2 address/write-data FIFOs.

Parameters:
FRAME_W, 800, frame width in pixels (multiple of 8)
FRAME_H, 600, frame height in pixels
X_W, 10, x coordinate width
Y_W, 10, y coordinate width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (asserted at 0)
valid  in  1  command request
ready  out  1  high in IDLE; a command is accepted when valid && ready
x0, x1  in  X_W  inclusive left/right pixel bounds
y0, y1  in  Y_W  inclusive top/bottom row bounds
color  in  24  fill colour
frame_base  in  32  framebuffer base; bits [27:22] select the frame
af_full  in  1  address FIFO full
wdf_full  in  1  write-data FIFO full
af_addr_din  out  31  burst address
af_wr_en  out  1  address FIFO push
wdf_din  out  128  write data beat
wdf_wr_en  out  1  write-data FIFO push
wdf_mask_din  out  16  byte mask, 1 = byte not written
done  out  1  one-cycle pulse when the last beat of a command is pushed

Behaviour:
- Reset: state IDLE; ready=1; done=0; af_wr_en=0; wdf_wr_en=0. Coordinate registers cleared. Reset mid-fill aborts immediately with no further pushes.
- Accept: valid && ready in IDLE latches x0,x1,y0,y1,color,frame_base. Burst x xb starts at {x0[X_W-1:3],3'b0}; row yr starts at y0. Next state is CMD.
- CMD: af_wr_en = wdf_wr_en = !af_full && !wdf_full (combinational). Both FIFOs are pushed together with beat 0, then the block goes to DATA2. If either FIFO is full, nothing is pushed and the state holds.
- DATA2: wdf_wr_en = !wdf_full. Beat 1 is pushed, then:
  - if xb+8 <= x1: xb += 8, go to CMD;
  - else if yr < y1: yr += 1, xb restarts, go to CMD;
  - else: pulse done, go to IDLE.
- Throughput: 2 cycles per burst with no backpressure. ready is low from the accept cycle until the cycle after done.
- Address: af_addr_din = {6'b0, frame_base[27:22], yr[9:0], xb[9:3], 2'b00}.
- Data: pixel p (0..3) of a beat occupies wdf_din[32p+31:32p] = {8'h00, color}. Beat b covers pixels xb+4b+p.
- Mask: wdf_mask_din[4p+3:4p] = 4'hF if the pixel is < x0 or > x1, else 4'h0.
- Degenerate input (x0>x1 or y0>y1): not filtered in base build. Arithmetic wraps modulo field width.

Optional Feature:
RECT_FILLER_CLIP_EN
- With the macro defined: at accept, x1 and y1 are clamped to FRAME_W-1 and FRAME_H-1. A command with x0>x1, y0>y1, x0>=FRAME_W or y0>=FRAME_H is accepted, makes no pushes, and pulses done on the next cycle.
- Without the macro: coordinates are used unmodified.

Decomposition:
- Package rect_filler_pkg holds:
  - the state encoding: IDLE=2'd0, CMD=2'd1, DATA2=2'd2;
  - PIX_PER_BURST=8, PIX_PER_BEAT=4, BYTES_PER_PIX=4;
  - the address-field widths.
- One sub-module, rect_filler_mask: combinational edge-mask generator. Inputs xb, beat, x0, x1; output the 16-bit mask.

Test Plan:
- Full frame 0..799 x 0..599, no backpressure -> 60000 af pushes, 120000 wdf pushes, all masks 16'h0000, one done pulse, 120000 cycles from accept to done.
- Rect x0=3, x1=12, y0=y1=5, frame_base=32'h1040_0000 -> two bursts with addresses 31'h80A00 and 31'h80A04:
  - burst 0 masks: 16'h0FFF then 16'h0000;
  - burst 1 masks: 16'h0000 then 16'hFFF0.
- af_full held high for 5 cycles while in CMD -> no af/wdf push during those cycles; pushes resume the cycle af_full falls; address unchanged.
- wdf_full held high for 3 cycles in DATA2 -> af_wr_en stays 0, beat 1 is pushed once after release, no duplicate.
- rst driven low mid-fill (between clock edges) -> all enables drop asynchronously, ready=1, and a new command after release starts from its own x0,y0.
- With RECT_FILLER_CLIP_EN: x1=1000, y1=700 on 0,0 origin -> last address row 599 / xb 792. With x0=900: zero pushes, done one cycle after accept.
